// File: rtl/pc_control_pkg.sv
// -----------------------------------------------------------------------------
// pc_ctrl_pkg
// Shared definitions for the next-PC sequencer and the call/return stack it
// feeds: the sequencer state encoding, the default reset and trap addresses,
// and the usable stack depth (also the stack's own acceptance limit).
// -----------------------------------------------------------------------------
package pc_ctrl_pkg;

  // RUN sequences normally; RET_WAIT covers the stack's registered read.
  typedef enum logic {
    RUN      = 1'b0,
    RET_WAIT = 1'b1
  } pc_state_t;

  // Width of the mirrored occupancy count (0..31 fits in 6 bits).
  localparam int unsigned DEPTH_W = 6;

  // The stack accepts a push only while its top pointer is below this value.
  localparam int unsigned STACK_DEPTH_DEFAULT = 31;

  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0004;

endpackage

// File: rtl/pc_control_if.sv
// -----------------------------------------------------------------------------
// pc_control_if
// Push/pop bus between the next-PC sequencer (master) and the call/return
// stack (slave).
//   stk_write    : push strobe, sequencer -> stack
//   stk_read     : pop strobe, sequencer -> stack
//   stk_data_in  : return address to push, sequencer -> stack
//   stk_data_out : popped address, stack -> sequencer, valid the cycle after
//                  stk_read (registered read inside the stack)
// -----------------------------------------------------------------------------
interface pc_control_if #(
  parameter int unsigned PC_WIDTH = 32
) ();

  logic                stk_write;
  logic                stk_read;
  logic [PC_WIDTH-1:0] stk_data_in;
  logic [PC_WIDTH-1:0] stk_data_out;

  modport master (
    output stk_write,
    output stk_read,
    output stk_data_in,
    input  stk_data_out
  );

  modport slave (
    input  stk_write,
    input  stk_read,
    input  stk_data_in,
    output stk_data_out
  );

endinterface

// File: rtl/pc_control_ras_depth_counter.sv
// -----------------------------------------------------------------------------
// ras_depth_counter
// Saturating up/down counter that mirrors the call/return stack occupancy.
// It never wraps: increments stop at MAX, decrements stop at zero.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   inc, dec   : one push / one pop this cycle (never both from the sequencer)
//   count      : current occupancy
//   full       : count == MAX
//   empty      : count == 0
// -----------------------------------------------------------------------------
module ras_depth_counter #(
  parameter int unsigned MAX = 31,
  parameter int unsigned W   = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty
);

  assign full  = (count == W'(MAX));
  assign empty = (count == '0);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs from before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !full) begin
      count <= count + W'(1);
    end else if (dec && !empty) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/pc_control.sv
// -----------------------------------------------------------------------------
// pc_control
// Next-PC sequencer in front of the call/return stack. Pushes pc+1 on CALL,
// pops on RET and spends one RET_WAIT cycle collecting the stack's registered
// read data. Occupancy is mirrored locally so that over- and underflowing ops
// (which the stack would silently drop) are squashed and flagged.
//
// Build option: define STACK_FAULT_TRAP_EN to redirect a faulting CALL/RET to
// TRAP_VECTOR; otherwise the faulting op falls through to pc+1.
//
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   stall            : hold pc/depth/state in RUN, no strobes
//   instr_valid      : decode outputs valid
//   op_call/op_ret/op_jump/op_branch_taken : decoded control ops
//   target           : jump/branch/call destination
//   stk              : stack push/pop bus (master side)
//   pc               : registered fetch address
//   busy             : high in RET_WAIT
//   stack_fault      : sticky over/underflow flag, cleared by reset only
//   depth            : mirrored stack occupancy
// -----------------------------------------------------------------------------
module pc_control
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned         PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(RESET_PC_DEFAULT),
  parameter int unsigned         STACK_DEPTH = STACK_DEPTH_DEFAULT
`ifdef STACK_FAULT_TRAP_EN
  ,
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR = PC_WIDTH'(TRAP_VECTOR_DEFAULT)
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                instr_valid,
  input  logic                op_call,
  input  logic                op_ret,
  input  logic                op_jump,
  input  logic                op_branch_taken,
  input  logic [PC_WIDTH-1:0] target,
  pc_control_if.master        stk,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                stack_fault,
  output logic [DEPTH_W-1:0]  depth
);

  pc_state_t           state_q;
  pc_state_t           state_d;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] pc_plus1;
  logic [PC_WIDTH-1:0] fault_pc;
  logic                fault_set;
  logic                push;
  logic                pop;
  logic                depth_full;
  logic                depth_empty;

  // Wraps modulo 2^PC_WIDTH by construction.
  assign pc_plus1 = pc + PC_WIDTH'(1);

`ifdef STACK_FAULT_TRAP_EN
  assign fault_pc = TRAP_VECTOR;
`else
  assign fault_pc = pc_plus1;
`endif

  assign stk.stk_write   = push;
  assign stk.stk_read    = pop;
  assign stk.stk_data_in = pc_plus1;
  assign busy            = (state_q == RET_WAIT);

  ras_depth_counter #(
    .MAX (STACK_DEPTH),
    .W   (DEPTH_W)
  ) u_depth (
    .clk   (clk),
    .reset (reset),
    .inc   (push),
    .dec   (pop),
    .count (depth),
    .full  (depth_full),
    .empty (depth_empty)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc;
    push      = 1'b0;
    pop       = 1'b0;
    fault_set = 1'b0;

    unique case (state_q)
      RUN: begin
        if (stall) begin
          // Hold everything.
        end else if (!instr_valid) begin
          pc_d = pc_plus1;
        end else if (op_ret) begin
          if (!depth_empty) begin
            pop     = 1'b1;
            state_d = RET_WAIT;
          end else begin
            fault_set = 1'b1;
            pc_d      = fault_pc;
          end
        end else if (op_call) begin
          if (!depth_full) begin
            push = 1'b1;
            pc_d = target;
          end else begin
            fault_set = 1'b1;
            pc_d      = fault_pc;
          end
        end else if (op_jump || op_branch_taken) begin
          pc_d = target;
        end else begin
          pc_d = pc_plus1;
        end
      end

      RET_WAIT: begin
        // No new read is issued here, so the stack output is still the
        // popped entry; stall and instr_valid are deliberately ignored.
        pc_d    = stk.stk_data_out;
        state_d = RUN;
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      pc          <= RESET_PC;
      stack_fault <= 1'b0;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      if (fault_set) begin
        stack_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_control.sv
// -----------------------------------------------------------------------------
// tb_pc_control
// Self-checking bench for pc_control. A behavioural stack answers the DUT's
// strobes; an independent model of the sequencer pushes expected strobes and
// post-edge state into a scoreboard queue as each cycle's stimulus is driven.
// -----------------------------------------------------------------------------
module tb_pc_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        instr_valid = 1'b0;
  logic        op_call = 1'b0;
  logic        op_ret = 1'b0;
  logic        op_jump = 1'b0;
  logic        op_branch_taken = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] pc;
  logic        busy;
  logic        stack_fault;
  logic [5:0]  depth;

  int n_checks = 0;
  int n_errors = 0;

  pc_control_if #(.PC_WIDTH(32)) stk_if ();

  pc_control dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .instr_valid     (instr_valid),
    .op_call         (op_call),
    .op_ret          (op_ret),
    .op_jump         (op_jump),
    .op_branch_taken (op_branch_taken),
    .target          (target),
    .stk             (stk_if),
    .pc              (pc),
    .busy            (busy),
    .stack_fault     (stack_fault),
    .depth           (depth)
  );

  always #5 clk = ~clk;

  // Behavioural call/return stack: 31 usable entries, registered read,
  // silently ignores overflowing pushes and underflowing pops.
  logic [31:0] env_mem [0:31];
  int          env_top;
  initial stk_if.stk_data_out = '0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      env_top <= 0;
    end else if (stk_if.stk_write && env_top < 31) begin
      env_mem[env_top] <= stk_if.stk_data_in;
      env_top          <= env_top + 1;
    end else if (stk_if.stk_read && env_top > 0) begin
      stk_if.stk_data_out <= env_mem[env_top-1];
      env_top             <= env_top - 1;
    end
  end

  // ---------------------------------------------------------------- model
  typedef struct {
    logic v; logic st; logic call; logic ret; logic jmp; logic br;
    logic [31:0] tgt;
  } stim_t;

  typedef struct {
    logic wr; logic rd; logic [31:0] din;
    logic [31:0] pc; logic [5:0] depth; logic busy; logic fault;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_stack[$];
  logic [31:0] m_pc;
  logic [31:0] m_ret_pc;
  logic        m_busy;
  logic        m_fault;

  function automatic logic [31:0] model_fault_pc(input logic [31:0] cur);
`ifdef STACK_FAULT_TRAP_EN
    return 32'h0000_0004;
`else
    return cur + 32'd1;
`endif
  endfunction

  function automatic stim_t mk(input logic v, st, call, ret, jmp, br,
                               input logic [31:0] tgt);
    stim_t s;
    s.v = v; s.st = st; s.call = call; s.ret = ret; s.jmp = jmp; s.br = br;
    s.tgt = tgt;
    return s;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_busy = 1'b0; m_fault = 1'b0;
    m_stack.delete();
    sb.delete();
  endtask

  // Drive one cycle's inputs and push what the model expects for it.
  task automatic drive(input stim_t s);
    exp_t e;
    instr_valid = s.v; stall = s.st; op_call = s.call; op_ret = s.ret;
    op_jump = s.jmp; op_branch_taken = s.br; target = s.tgt;
    e.wr = 1'b0; e.rd = 1'b0; e.din = m_pc + 32'd1;
    if (m_busy) begin
      m_pc = m_ret_pc; m_busy = 1'b0;
    end else if (s.st) begin
    end else if (!s.v) begin
      m_pc = m_pc + 32'd1;
    end else if (s.ret) begin
      if (m_stack.size() > 0) begin
        e.rd = 1'b1; m_ret_pc = m_stack.pop_back(); m_busy = 1'b1;
      end else begin
        m_fault = 1'b1; m_pc = model_fault_pc(m_pc);
      end
    end else if (s.call) begin
      if (m_stack.size() < 31) begin
        e.wr = 1'b1; m_stack.push_back(m_pc + 32'd1); m_pc = s.tgt;
      end else begin
        m_fault = 1'b1; m_pc = model_fault_pc(m_pc);
      end
    end else if (s.jmp || s.br) begin
      m_pc = s.tgt;
    end else begin
      m_pc = m_pc + 32'd1;
    end
    e.pc = m_pc; e.depth = 6'(m_stack.size()); e.busy = m_busy; e.fault = m_fault;
    sb.push_back(e);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    model_reset();
    #1;
    n_checks++;
    if ({pc, depth, busy, stack_fault} !== {32'h0, 6'd0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_state: got pc=%h depth=%0d busy=%b fault=%b want 0/0/0/0",
               pc, depth, busy, stack_fault);
    end
    n_checks++;
    if ({stk_if.stk_write, stk_if.stk_read} !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_strobes: got wr=%b rd=%b want 0 0",
               stk_if.stk_write, stk_if.stk_read);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_stims(input string name, input stim_t s[$]);
    exp_t e;
    foreach (s[i]) begin
      drive(s[i]);
      #1;
      n_checks++;
      if ({stk_if.stk_write, stk_if.stk_read, stk_if.stk_data_in} !==
          {sb[0].wr, sb[0].rd, sb[0].din}) begin
        n_errors++;
        $display("FAIL %s_strobe[%0d]: got wr=%b rd=%b din=%h want wr=%b rd=%b din=%h",
                 name, i, stk_if.stk_write, stk_if.stk_read, stk_if.stk_data_in,
                 sb[0].wr, sb[0].rd, sb[0].din);
      end
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if ({pc, depth, busy, stack_fault} !== {e.pc, e.depth, e.busy, e.fault}) begin
        n_errors++;
        $display("FAIL %s_state[%0d]: got pc=%h depth=%0d busy=%b fault=%b want pc=%h depth=%0d busy=%b fault=%b",
                 name, i, pc, depth, busy, stack_fault, e.pc, e.depth, e.busy, e.fault);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_idle();
    stim_t s[$];
    repeat (4) s.push_back(mk(0, 0, 0, 0, 0, 0, 32'hFFFF));
    run_stims("idle", s);
    n_checks++;
    if (pc !== 32'h4) begin
      n_errors++;
      $display("FAIL idle_pc: got %h want 00000004", pc);
    end
  endtask

  task automatic test_call_ret();
    stim_t s[$];
    s.push_back(mk(1, 0, 0, 0, 1, 0, 32'h10));          // jump to 0x10
    run_stims("to10", s);
    s.delete();
    s.push_back(mk(1, 0, 1, 0, 0, 0, 32'h40));          // CALL 0x40
    drive(s[0]);
    #1;
    n_checks++;
    if ({stk_if.stk_write, stk_if.stk_read, stk_if.stk_data_in} !== {1'b1, 1'b0, 32'h11}) begin
      n_errors++;
      $display("FAIL call_push: got wr=%b rd=%b din=%h want 1 0 00000011",
               stk_if.stk_write, stk_if.stk_read, stk_if.stk_data_in);
    end
    @(posedge clk);
    #1;
    void'(sb.pop_front());
    n_checks++;
    if ({pc, depth} !== {32'h40, 6'd1}) begin
      n_errors++;
      $display("FAIL call_target: got pc=%h depth=%0d want 00000040 1", pc, depth);
    end
    @(negedge clk);
    s.delete();
    repeat (5) s.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0)); // sequential to 0x45
    s.push_back(mk(1, 0, 0, 1, 0, 0, 32'h0));            // RET
    s.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0));            // RET_WAIT
    run_stims("ret", s);
    n_checks++;
    if ({pc, depth, busy} !== {32'h11, 6'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL ret_return: got pc=%h depth=%0d busy=%b want 00000011 0 0",
               pc, depth, busy);
    end
  endtask

  task automatic test_underflow();
    stim_t s[$];
    s.push_back(mk(1, 0, 0, 1, 0, 0, 32'h0));
    s.push_back(mk(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFF));    // branch to top
    s.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0));            // wrap to 0
    s.push_back(mk(1, 1, 1, 0, 0, 0, 32'h77));           // stalled call
    run_stims("underflow", s);
  endtask

  task automatic test_overflow();
    stim_t s[$];
    for (int i = 0; i < 31; i++) s.push_back(mk(1, 0, 1, 0, 0, 0, 32'h1000 + 32'(i * 16)));
    s.push_back(mk(1, 0, 1, 0, 0, 0, 32'hDEAD));         // 32nd CALL
    run_stims("overflow", s);
    n_checks++;
    if ({depth, stack_fault} !== {6'd31, 1'b1}) begin
      n_errors++;
      $display("FAIL overflow_depth: got depth=%0d fault=%b want 31 1", depth, stack_fault);
    end
  endtask

  task automatic test_priority();
    stim_t s[$];
    s.push_back(mk(1, 0, 0, 1, 1, 0, 32'h999));          // ret beats jump
    s.push_back(mk(1, 1, 1, 0, 0, 0, 32'h555));          // stall in RET_WAIT
    s.push_back(mk(1, 0, 0, 1, 0, 0, 32'h0));            // back-to-back RET
    s.push_back(mk(1, 0, 1, 0, 1, 1, 32'h2000));         // call during wait: ignored
    s.push_back(mk(1, 0, 1, 0, 1, 1, 32'h2000));         // call beats jump
    run_stims("priority", s);
  endtask

  task automatic test_reset_in_wait();
    stim_t s[$];
    s.push_back(mk(1, 0, 0, 1, 0, 0, 32'h0));
    run_stims("pre_reset", s);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({pc, busy, depth, stack_fault} !== {32'h0, 1'b0, 6'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_in_wait: got pc=%h busy=%b depth=%0d fault=%b want 0 0 0 0",
               pc, busy, depth, stack_fault);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    s.delete();
    repeat (2) s.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0));
    run_stims("post_reset", s);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_idle();
    test_call_ret();
    test_underflow();
    test_reset();
    test_overflow();
    test_priority();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timed out");
  end

endmodule

// File: doc/pc_control.md
Name: pc_control

Overview:
- Next-PC sequencer sitting directly upstream of the call/return stack.
- Drives the program counter and generates the stack's write/read strobes:
  - pushes the return address on CALL;
  - pops it on RET and waits out the stack's one-cycle registered read.
- Mirrors stack occupancy to block over- and underflow, which the stack silently ignores.

Parameters:
- PC_WIDTH, 32, width of pc and of the stack data path.
- RESET_PC, 0, pc value on reset.
- STACK_DEPTH, 31, usable stack entries (the stack accepts pushes only while top < 31).
- TRAP_VECTOR, 32'h0000_0004, fault target; used only with STACK_FAULT_TRAP_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  holds pc and suppresses all stack strobes.
- instr_valid  in  1  decode outputs valid this cycle.
- op_call  in  1  CALL decoded.
- op_ret  in  1  RET decoded.
- op_jump  in  1  unconditional jump decoded.
- op_branch_taken  in  1  conditional branch resolved taken.
- target  in  PC_WIDTH  jump/branch/call destination.
- stk_data_out  in  PC_WIDTH  popped value from the stack (valid the cycle after stk_read).
- pc  out  PC_WIDTH  current fetch address (registered).
- stk_write  out  1  push strobe (combinational).
- stk_read  out  1  pop strobe (combinational).
- stk_data_in  out  PC_WIDTH  push data, equal to pc+1.
- busy  out  1  high in RET_WAIT; fetch must not advance.
- stack_fault  out  1  sticky overflow/underflow flag.
- depth  out  6  mirrored stack occupancy, 0..STACK_DEPTH.

Behaviour:

Reset:
- pc=RESET_PC, state=RUN, depth=0, stack_fault=0, busy=0, stk_write=0, stk_read=0.
- The stack's top pointer has no reset, so system reset must coincide with power-up for depth to stay coherent.

States:
- RUN: normal sequencing.
- RET_WAIT: one cycle, waiting on the stack's registered read.

RUN, when instr_valid=1 and stall=0. Priority: op_ret > op_call > op_jump > op_branch_taken > sequential.
- RET with depth>0:
  - stk_read=1, depth-1, pc held, next state RET_WAIT.
- RET with depth==0 (underflow):
  - stk_read=0, stack_fault<=1, pc<=pc+1.
- CALL with depth<STACK_DEPTH:
  - stk_write=1, stk_data_in=pc+1, depth+1, pc<=target.
- CALL with depth==STACK_DEPTH (overflow):
  - stk_write=0, stack_fault<=1, pc<=pc+1; the call is squashed.
- Jump or branch taken: pc<=target.
- Otherwise: pc<=pc+1.

RUN, other cases:
- instr_valid=0: pc<=pc+1 with no strobes.
- stall=1: pc, depth and state held; strobes 0.

RET_WAIT:
- busy=1, strobes 0.
- pc<=stk_data_out; next state RUN.
- Completes regardless of stall or instr_valid; stk_data_out is stable because no further read is issued.

Timing and arithmetic:
- RET latency is 2 cycles from the strobe cycle to the return pc; CALL/jump/branch latency is 1 cycle.
- pc arithmetic is modulo 2^PC_WIDTH: pc=FFFF_FFFF → pc+1=0.
- depth never wraps.
- stk_write and stk_read are never both high.
- stack_fault clears only on reset.
- Reset asserted during RET_WAIT: state=RUN, pc=RESET_PC; the pending pop is dropped.

Optional Feature:
STACK_FAULT_TRAP_EN:
- Defined: on overflow or underflow, pc<=TRAP_VECTOR instead of pc+1; stack_fault is still set.
- Undefined: the faulting op is squashed and pc<=pc+1.
- Strobe behaviour is identical in both builds.

Decomposition:
- Shared package pc_ctrl_pkg holds:
  - state encoding (RUN=1'b0, RET_WAIT=1'b1);
  - default RESET_PC and TRAP_VECTOR constants;
  - the STACK_DEPTH default, shared with the stack.
- One sub-module, ras_depth_counter: saturating up/down counter with full/empty outputs, instantiated once. Next-PC selection stays inline.

Test Plan:
- Reset then 4 idle cycles with instr_valid=0 → pc=0,1,2,3,4; strobes never high.
- At pc=0x10, CALL with target=0x40 → stk_write=1 with stk_data_in=0x11 that cycle; next pc=0x40; depth=1.
- Then RET at pc=0x45 → stk_read=1, pc holds 0x45, busy=1 next cycle; the following cycle pc=0x11, depth=0.
- 31 nested CALLs then a 32nd → 32nd has stk_write=0, stack_fault=1, pc=pc+1 (TRAP_VECTOR=0x4 when STACK_FAULT_TRAP_EN); depth stays 31.
- RET with depth=0 → stk_read=0, stack_fault=1, pc advances by 1.
- op_ret and op_jump both asserted, plus stall during RET_WAIT → ret wins; RET_WAIT still loads the popped pc. Async reset mid RET_WAIT → pc=0 immediately, busy=0.
